// File: rtl/alu_issue_queue.sv
// alu_issue_queue: a small in-order FIFO that sits in front of the 2-bit ALU.
// It accepts requests, issues at most one per cycle as registered operands and
// controls, and captures the ALU's combinational result one cycle after issue.
// It also keeps a saturating count of divide-by-zero results.
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_a,
  input  logic [1:0]                in_b,
  input  logic [1:0]                in_ctrl,
  input  logic [1:0]                in_addr,
  input  logic                      in_we,
  input  logic                      hold,
  output logic [1:0]                alu_a,
  output logic [1:0]                alu_b,
  output logic [1:0]                alu_ctrl,
  output logic [1:0]                alu_addr,
  output logic                      alu_we,
  input  logic [3:0]                alu_y,
  input  logic                      alu_c,
  output logic                      res_valid,
  output logic [3:0]                res_y,
  output logic                      res_c,
  output logic [1:0]                res_addr,
  output logic [3:0]                err_cnt,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry layout: {a[8:7], b[6:5], ctrl[4:3], addr[2:1], we[0]}
  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          iss_valid;
  logic          push;
  logic          pop;

  // Acceptance depends only on occupancy, so a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  assign in_ready = (count < CW'(DEPTH)) && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = !hold && (count != '0);

  // Storage write port; contents need no reset because count guards reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b, in_ctrl, in_addr, in_we};
    end
  end

  // Pointers, occupancy and the issue registers (registered read of the head)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      iss_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      alu_addr  <= '0;
      alu_we    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        {alu_a, alu_b, alu_ctrl, alu_addr, alu_we} <= mem[rd_ptr];
        iss_valid <= 1'b1;
      end else begin
        // Operands hold their last values; only the write enable is gated
        iss_valid <= 1'b0;
        alu_we    <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Capture the ALU result one cycle after issue and track div-by-zero errors
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_y     <= '0;
      res_c     <= 1'b0;
      res_addr  <= '0;
      err_cnt   <= '0;
    end else begin
      res_valid <= iss_valid;
      if (iss_valid) begin
        res_y    <= alu_y;
        res_c    <= alu_c;
        res_addr <= alu_addr;
        if ((alu_ctrl == 2'b11) && alu_c && (err_cnt != 4'hF)) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed testbench for alu_issue_queue with a behavioural 2-bit ALU model.
module tb_alu_issue_queue;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_a, in_b, in_ctrl, in_addr;
  logic       in_we;
  logic       hold;
  logic [1:0] alu_a, alu_b, alu_ctrl, alu_addr;
  logic       alu_we;
  logic [3:0] alu_y;
  logic       alu_c;
  logic       res_valid;
  logic [3:0] res_y;
  logic       res_c;
  logic [1:0] res_addr;
  logic [3:0] err_cnt;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  alu_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .in_addr(in_addr),
    .in_we(in_we), .hold(hold),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_addr(alu_addr),
    .alu_we(alu_we), .alu_y(alu_y), .alu_c(alu_c),
    .res_valid(res_valid), .res_y(res_y), .res_c(res_c), .res_addr(res_addr),
    .err_cnt(err_cnt), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU stand-in: add, sub (borrow), mul, div (c = div by zero)
  always_comb begin
    alu_y = 4'h0;
    alu_c = 1'b0;
    case (alu_ctrl)
      2'b00: alu_y = {2'b00, alu_a} + {2'b00, alu_b};
      2'b01: begin
        alu_y = {2'b00, alu_a} - {2'b00, alu_b};
        alu_c = (alu_a < alu_b);
      end
      2'b10: alu_y = {2'b00, alu_a} * {2'b00, alu_b};
      default: begin
        if (alu_b == 2'b00) begin
          alu_y = 4'h0;
          alu_c = 1'b1;
        end else begin
          alu_y = {2'b00, alu_a} / {2'b00, alu_b};
        end
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] ctrl, input logic [1:0] addr,
                        input logic we);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_ctrl = ctrl; in_addr = addr; in_we = we;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0;
    in_a = 0; in_b = 0; in_ctrl = 0; in_addr = 0; in_we = 0;
    tick(); tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (res_valid !== 1'b0 || alu_we !== 1'b0) begin errors++; $display("FAIL reset_valids got=%b%b exp=00", res_valid, alu_we); end
    checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_add();
    set_op(2'd3, 2'd2, 2'b00, 2'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL add_count got=%0d exp=1", count); end
    tick();
    checks++; if ({alu_a, alu_b, alu_ctrl, alu_addr, alu_we} !== {2'd3, 2'd2, 2'b00, 2'd1, 1'b1}) begin
      errors++; $display("FAIL add_issue got=%0d,%0d,%0d,%0d,%b exp=3,2,0,1,1", alu_a, alu_b, alu_ctrl, alu_addr, alu_we);
    end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_early_res got=%b exp=0", res_valid); end
    tick();
    checks++; if ({res_valid, res_y, res_c, res_addr} !== {1'b1, 4'd5, 1'b0, 2'd1}) begin
      errors++; $display("FAIL add_result got=v%b y%0d c%b addr%0d exp=v1 y5 c0 addr1", res_valid, res_y, res_c, res_addr);
    end
    checks++; if (alu_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL add_after got=we%b cnt%0d exp=we0 cnt0", alu_we, count); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_pulse got=%b exp=0", res_valid); end
    $display("test_add done res_y=%0d", res_y);
  endtask

  task automatic test_sub();
    set_op(2'd1, 2'd2, 2'b01, 2'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if ({res_valid, res_y, res_c, res_addr} !== {1'b1, 4'hF, 1'b1, 2'd3}) begin
      errors++; $display("FAIL sub_result got=v%b y%0h c%b addr%0d exp=v1 yf c1 addr3", res_valid, res_y, res_c, res_addr);
    end
    checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL sub_err_cnt got=%0d exp=0", err_cnt); end
    $display("test_sub done res_y=%0h", res_y);
  endtask

  task automatic test_div_err();
    int pulses;
    set_op(2'd2, 2'd0, 2'b11, 2'd2, 1'b1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if ({res_valid, res_y, res_c, res_addr} !== {1'b1, 4'd0, 1'b1, 2'd2}) begin
      errors++; $display("FAIL div0_result got=v%b y%0d c%b addr%0d exp=v1 y0 c1 addr2", res_valid, res_y, res_c, res_addr);
    end
    checks++; if (err_cnt !== 4'd1) begin errors++; $display("FAIL div0_err_first got=%0d exp=1", err_cnt); end
    pulses = 0;
    set_op(2'd2, 2'd0, 2'b11, 2'd2, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (res_valid) pulses++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (res_valid) pulses++;
    end
    checks++; if (pulses !== 20) begin errors++; $display("FAIL div0_pulses got=%0d exp=20", pulses); end
    checks++; if (err_cnt !== 4'd15) begin errors++; $display("FAIL div0_saturate got=%0d exp=15", err_cnt); end
    $display("test_div_err done err_cnt=%0d", err_cnt);
  endtask

  task automatic test_hold();
    logic [3:0] exp_y [4];
    logic [3:0] got_y [4];
    int cyc [4];
    int n;
    int early;
    exp_y[0] = 4'd9; exp_y[1] = 4'd2; exp_y[2] = 4'd3; exp_y[3] = 4'd1;
    early = 0;
    hold = 1'b1;
    set_op(2'd3, 2'd3, 2'b10, 2'd0, 1'b1); tick(); early += int'(res_valid);
    set_op(2'd1, 2'd1, 2'b00, 2'd1, 1'b1); tick(); early += int'(res_valid);
    set_op(2'd3, 2'd1, 2'b11, 2'd2, 1'b1); tick(); early += int'(res_valid);
    set_op(2'd2, 2'd1, 2'b01, 2'd3, 1'b1); tick(); early += int'(res_valid);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL hold_full_count got=%0d exp=4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_full_ready got=%b exp=0", in_ready); end
    set_op(2'd3, 2'd3, 2'b00, 2'd0, 1'b1); tick(); early += int'(res_valid);
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL hold_fifth_push got=%0d exp=4", count); end
    checks++; if (early !== 0) begin errors++; $display("FAIL hold_no_issue got=%0d exp=0", early); end
    hold = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid) begin
        if (n < 4) begin got_y[n] = res_y; cyc[n] = i; end
        n++;
      end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL hold_result_count got=%0d exp=4", n); end
    if (n >= 4) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_y[k] !== exp_y[k]) begin errors++; $display("FAIL hold_order[%0d] got=%0d exp=%0d", k, got_y[k], exp_y[k]); end
      end
      checks++; if (cyc[3] - cyc[0] !== 3) begin errors++; $display("FAIL hold_back_to_back got=span%0d exp=span3", cyc[3] - cyc[0]); end
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL hold_drain_count got=%0d exp=0", count); end
    $display("test_hold done results=%0d", n);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_y [12];
    logic [1:0] exp_addr [12];
    int n;
    int bad;
    for (int i = 0; i < 12; i++) begin
      exp_y[i] = 4'((i % 4) + ((i / 4) % 4));
      exp_addr[i] = 2'(i % 4);
    end
    n = 0; bad = 0;
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_op(2'(i % 4), 2'((i / 4) % 4), 2'b00, 2'(i % 4), 1'b1);
      tick();
    end
    hold = 1'b0;
    for (int i = 2; i < 12; i++) begin
      set_op(2'(i % 4), 2'((i / 4) % 4), 2'b00, 2'(i % 4), 1'b1);
      tick();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count cycle=%0d got=%0d exp=2", i, count); end
      if (res_valid) begin
        if (n < 12 && (res_y !== exp_y[n] || res_addr !== exp_addr[n])) bad++;
        n++;
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_valid) begin
        if (n < 12 && (res_y !== exp_y[n] || res_addr !== exp_addr[n])) bad++;
        n++;
      end
    end
    checks++; if (n !== 12) begin errors++; $display("FAIL b2b_result_count got=%0d exp=12", n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_order got=%0d_wrong exp=0_wrong", bad); end
    $display("test_back_to_back done results=%0d", n);
  endtask

  task automatic test_reset_mid();
    int late;
    hold = 1'b1;
    set_op(2'd1, 2'd0, 2'b11, 2'd1, 1'b1); tick();
    set_op(2'd1, 2'd1, 2'b00, 2'd2, 1'b1); tick();
    set_op(2'd2, 2'd2, 2'b10, 2'd3, 1'b1); tick();
    in_valid = 1'b0;
    hold = 1'b0;
    tick();
    checks++; if (count !== 3'd2 || alu_we !== 1'b1) begin errors++; $display("FAIL rstmid_issue got=cnt%0d we%b exp=cnt2 we1", count, alu_we); end
    rst = 1'b1;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_res_valid got=%b exp=0", res_valid); end
    checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL rstmid_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (in_ready !== 1'b0 || alu_we !== 1'b0) begin errors++; $display("FAIL rstmid_during got=rdy%b we%b exp=rdy0 we0", in_ready, alu_we); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after got=%b exp=1", in_ready); end
    late = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (res_valid) late++;
    end
    checks++; if (late !== 0 || count !== 3'd0) begin errors++; $display("FAIL rstmid_discard got=pulses%0d cnt%0d exp=pulses0 cnt0", late, count); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_div_err();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Upstream issue stage for the 2-bit ALU/result-memory block. Buffers operation requests from the controller in a small FIFO and issues one per cycle as registered operand/control signals. It then captures the ALU's combinational result (y, c) one cycle later into a result register, alongside a saturating divide-by-zero error counter. This gives the otherwise purely combinational ALU a clocked, flow-controlled front end and a stable result tap.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  FIFO can accept; = (count < DEPTH) && !rst
- in_a, in_b  in  2 each  operands
- in_ctrl  in  2  00 add, 01 sub, 10 mul, 11 div
- in_addr  in  2  result memory address
- in_we  in  1  result memory write enable
- hold  in  1  suspends issue; FIFO still accepts
- alu_a, alu_b, alu_ctrl, alu_addr  out  2 each  registered operands/controls to ALU
- alu_we  out  1  registered write enable; gated by issue
- alu_y  in  4  ALU result
- alu_c  in  1  ALU carry/borrow/div-by-zero flag
- res_valid  out  1  one-cycle pulse, result captured
- res_y  out  4  captured alu_y
- res_c  out  1  captured alu_c
- res_addr  out  2  address of captured op
- err_cnt  out  4  saturating count of div-by-zero results
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Entry = {a, b, ctrl, addr, we}, 9 bits; circular buffer with wrapping read/write pointers plus occupancy counter.
- Push when in_valid && in_ready. No push when full, even if a pop occurs in the same cycle (in_ready depends only on count).
- Pop/issue when !hold && count > 0: head entry loads into alu_* registers; internal iss_valid <= 1; alu_we <= entry.we.
- No issue in a cycle: iss_valid <= 0, alu_we <= 0; alu_a/b/ctrl/addr hold their last values.
- Simultaneous push and pop: count unchanged, both pointers advance.
- An entry pushed into an empty FIFO is not issued in the same cycle (no bypass).
- Capture: at any edge where iss_valid == 1, res_y <= alu_y, res_c <= alu_c, res_addr <= alu_addr, res_valid <= 1. Otherwise res_valid <= 0 and res_* hold.
- err_cnt increments on capture when alu_ctrl == 11 and alu_c == 1; saturates at 15. Sub borrow (ctrl 01, c = 1) does not count.
- Pointer wrap: modulo DEPTH. count never exceeds DEPTH or goes below 0.

## Timing
- Reset (rst high at an edge): count, pointers, iss_valid, all alu_*, res_*, res_valid, and err_cnt go to 0. in_ready = 0 while rst is high and 1 on the first cycle after.
- Reset mid-operation discards queued and in-flight ops. No res_valid for a discarded op.
- Latency: push at edge N; alu_* valid after edge N+1; res_valid high for the cycle after edge N+2.
- Throughput: one op per cycle while the FIFO is non-empty and hold is low. Back-to-back res_valid pulses are allowed.
- hold asserted: the next edge issues nothing. An op issued on the previous edge still captures (res_valid still pulses once).
- FIFO ordering is strictly in-order: results appear in push order.

## Test plan
- Push add a=3, b=2, addr=1, we=1 at edge 0: alu_* = {3, 2, 00, 1}, alu_we = 1 after edge 1. After edge 2: res_valid = 1, res_y = 5, res_c = 0, res_addr = 1. alu_we = 0 after edge 2.
- Push div a=2, b=0: res_y = 0, res_c = 1, err_cnt 0 -> 1. Then 20 more such ops: err_cnt holds at 15.
- Push sub a=1, b=2: res_y = 4'hF, res_c = 1, err_cnt unchanged.
- hold = 1; push ops mul 3*3, add 1+1, div 3/1, sub 2-1: count = 4, in_ready = 0, fifth push ignored. Release hold: four consecutive res_valid pulses with res_y = 9, 2, 3, 1 in order; count returns to 0.
- Keep count = 2 with continuous push and issue for 10 cycles: count stays 2, pointers wrap, no ops lost or duplicated.
- Queue 3 ops, issue 1, assert rst for 1 cycle: count = 0, res_valid never pulses for the in-flight op, err_cnt = 0, in_ready = 1 the following cycle.
